// File: rtl/gcbp_corr_rd_sched_if.sv
// Signal bundle between the GCBP read-side scheduler (master) and the frame
// decoder / BRAM read port / correlator around it (slave).
interface gcbp_corr_rd_sched_if #(
  parameter int C_ADDR_W = 9
);
  logic                i_new_frame;
  logic [1:0]          i_curr_frame_loc;
  logic [1:0]          i_prev_frame_loc;
  logic                i_corr_ready;
  logic                o_rd_en;
  logic [C_ADDR_W-1:0] o_rd_addr;
  logic                o_data_valid;
  logic                o_data_is_curr;
  logic [5:0]          o_data_line;
  logic                o_frame_start;
  logic                o_frame_done;
  logic                o_busy;
  logic                o_overrun;

  modport master (
    input  i_new_frame, i_curr_frame_loc, i_prev_frame_loc, i_corr_ready,
    output o_rd_en, o_rd_addr, o_data_valid, o_data_is_curr, o_data_line,
           o_frame_start, o_frame_done, o_busy, o_overrun
  );

  modport slave (
    output i_new_frame, i_curr_frame_loc, i_prev_frame_loc, i_corr_ready,
    input  o_rd_en, o_rd_addr, o_data_valid, o_data_is_curr, o_data_line,
           o_frame_start, o_frame_done, o_busy, o_overrun
  );
endinterface

// File: rtl/gcbp_corr_rd_sched.sv
// GCBP read-side scheduler: streams previous/current sub-image lines, interleaved,
// from the BRAM read port and tags each returning word through a latency pipeline.
module gcbp_corr_rd_sched #(
  parameter int C_LINES           = 64,
  parameter int C_SUBIMAGE_OFFSET = 128,
  parameter int C_RD_LATENCY      = 2,
  parameter int C_ADDR_W          = 9
) (
  input logic                  i_clk,
  input logic                  i_reset,
  gcbp_corr_rd_sched_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int                  L          = C_RD_LATENCY;
  localparam logic [5:0]          LAST_LINE  = 6'(C_LINES - 1);
  localparam logic [C_ADDR_W-1:0] OFFSET     = C_ADDR_W'(C_SUBIMAGE_OFFSET);
  // Every pipeline stage except the output one; empty here means the pass is over after this edge.
  localparam logic [L-1:0]        EARLY_MASK = {L{1'b1}} >> 1;

  function automatic logic [C_ADDR_W-1:0] frame_base(input logic [1:0] loc);
    frame_base = C_ADDR_W'(loc) * OFFSET;
  endfunction

  logic [1:0]          state_r, state_next_s;
  logic [1:0]          frames_seen_r;
  logic                loc_cap_r;
  logic [1:0]          loc_prev_r, loc_curr_r, loc_prev_s, loc_curr_s;
  logic [5:0]          line_r, cur_line_s;
  logic                phase_r, cur_phase_s;
  logic                qual_s, overrun_s, issue_s, last_s, drained_s;
  logic [C_ADDR_W-1:0] issue_addr_s;
  logic                rd_en_r, rd_curr_r, rd_last_r;
  logic [C_ADDR_W-1:0] rd_addr_r;
  logic [5:0]          rd_line_r;
  logic [L-1:0]        valid_r, curr_r, last_r;
  logic [L-1:0][5:0]   line_pipe_r;
  logic [L:0]          valid_chain_s, curr_chain_s, last_chain_s;
  logic [L:0][5:0]     line_chain_s;
  logic                busy_r, frame_start_r, overrun_r;

  // Issue decision, next-read address and next-state selection
  always_comb begin
    qual_s        = bus.i_new_frame && (frames_seen_r != 2'd0);
    overrun_s     = qual_s && (state_r != S_IDLE);
    loc_prev_s    = loc_cap_r ? bus.i_prev_frame_loc : loc_prev_r;
    loc_curr_s    = loc_cap_r ? bus.i_curr_frame_loc : loc_curr_r;
    cur_line_s    = (state_r == S_LATCH) ? 6'd0 : line_r;
    cur_phase_s   = (state_r == S_LATCH) ? 1'b0 : phase_r;
    last_s        = cur_phase_s && (cur_line_s == LAST_LINE);
    issue_s       = !qual_s && bus.i_corr_ready &&
                    ((state_r == S_LATCH) || (state_r == S_ISSUE));
    issue_addr_s  = frame_base(cur_phase_s ? loc_curr_s : loc_prev_s) + C_ADDR_W'(cur_line_s);
    drained_s     = !rd_en_r && ((valid_r & EARLY_MASK) == '0);
    valid_chain_s = {valid_r, rd_en_r};
    curr_chain_s  = {curr_r, rd_curr_r};
    last_chain_s  = {last_r, rd_en_r & rd_last_r};
    line_chain_s  = {line_pipe_r, rd_line_r};
    state_next_s  = S_IDLE;
    case (state_r)
      S_IDLE:  state_next_s = qual_s ? S_LATCH : S_IDLE;
      S_LATCH: state_next_s = qual_s ? S_LATCH : S_ISSUE;
      S_ISSUE: state_next_s = qual_s ? S_LATCH : ((issue_s && last_s) ? S_DRAIN : S_ISSUE);
      S_DRAIN: state_next_s = qual_s ? S_LATCH : (drained_s ? S_IDLE : S_DRAIN);
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM, warm-up counter, location capture, read port and tagged valid pipeline
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= S_IDLE;
      frames_seen_r <= 2'd0;
      loc_cap_r     <= 1'b0;
      loc_prev_r    <= 2'd0;
      loc_curr_r    <= 2'd0;
      line_r        <= 6'd0;
      phase_r       <= 1'b0;
      rd_en_r       <= 1'b0;
      rd_addr_r     <= '0;
      rd_curr_r     <= 1'b0;
      rd_line_r     <= 6'd0;
      rd_last_r     <= 1'b0;
      valid_r       <= '0;
      curr_r        <= '0;
      last_r        <= '0;
      line_pipe_r   <= '0;
      busy_r        <= 1'b0;
      frame_start_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      busy_r        <= (state_next_s != S_IDLE);
      frame_start_r <= (state_next_s == S_LATCH);
      overrun_r     <= overrun_s;
      loc_cap_r     <= qual_s;
      if (bus.i_new_frame && (frames_seen_r != 2'd3)) begin
        frames_seen_r <= frames_seen_r + 2'd1;
      end
      if (loc_cap_r) begin
        loc_prev_r <= bus.i_prev_frame_loc;
        loc_curr_r <= bus.i_curr_frame_loc;
      end
      if (issue_s) begin
        phase_r <= ~cur_phase_s;
        line_r  <= cur_phase_s ? (cur_line_s + 6'd1) : cur_line_s;
      end else if (state_r == S_LATCH) begin
        phase_r <= 1'b0;
        line_r  <= 6'd0;
      end
      rd_en_r <= issue_s;
      if (issue_s) begin
        rd_addr_r <= issue_addr_s;
        rd_curr_r <= cur_phase_s;
        rd_line_r <= cur_line_s;
        rd_last_r <= last_s;
      end
      // An aborted pass must not leak stale words or a done pulse.
      valid_r     <= overrun_s ? '0 : valid_chain_s[L-1:0];
      last_r      <= overrun_s ? '0 : last_chain_s[L-1:0];
      curr_r      <= curr_chain_s[L-1:0];
      line_pipe_r <= line_chain_s[L-1:0];
    end
  end

  assign bus.o_rd_en        = rd_en_r;
  assign bus.o_rd_addr      = rd_addr_r;
  assign bus.o_data_valid   = valid_r[L-1];
  assign bus.o_data_is_curr = curr_r[L-1];
  assign bus.o_data_line    = line_pipe_r[L-1];
  assign bus.o_frame_done   = last_r[L-1];
  assign bus.o_frame_start  = frame_start_r;
  assign bus.o_busy         = busy_r;
  assign bus.o_overrun      = overrun_r;
endmodule

// File: tb/tb_gcbp_corr_rd_sched.sv
// Bench for gcbp_corr_rd_sched: event-queue reference model checked every cycle,
// plus directed passes with hand-computed cycle/address expectations.
module tb_gcbp_corr_rd_sched;
  localparam int LAT = 2;
  localparam int NL  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcbp_corr_rd_sched_if #(.C_ADDR_W(9)) bus ();

  gcbp_corr_rd_sched #(
    .C_LINES(NL), .C_SUBIMAGE_OFFSET(128), .C_RD_LATENCY(LAT), .C_ADDR_W(9)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a pass is a list of 2*NL reads; each read returns LAT cycles later.
  typedef struct { int t; bit curr; int line; bit last; } ev_t;
  ev_t evq[$];
  int  m_frames = 0, m_idx = 2 * NL, m_lc = 0, m_lp = 0;
  bit  m_latch = 1'b0, m_live = 1'b0;
  bit  e_rd, e_zero, e_valid, e_curr, e_done, e_start, e_ov;
  bit  e_busy = 1'b0;
  int  e_addr = 0, e_line = 0;

  always @(posedge clk) begin
    bit qual;
    bit cu;
    int ln;
    cyc++;
    e_rd = 1'b0; e_zero = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_start = 1'b0; e_ov = 1'b0;
    if (rst) begin
      m_frames = 0; m_latch = 1'b0; m_idx = 2 * NL; evq.delete();
      e_busy = 1'b0; e_zero = 1'b1; e_addr = 0; m_live = 1'b1;
    end else begin
      qual = bus.i_new_frame && (m_frames >= 1);
      if (bus.i_new_frame && m_frames < 3) m_frames++;
      if (qual) begin
        e_ov = e_busy; evq.delete(); m_latch = 1'b1; m_idx = 2 * NL; e_start = 1'b1;
      end else begin
        if (m_latch) begin
          m_latch = 1'b0; m_lc = int'(bus.i_curr_frame_loc); m_lp = int'(bus.i_prev_frame_loc); m_idx = 0;
        end
        if (m_idx < 2 * NL && bus.i_corr_ready) begin
          ln = m_idx / 2;
          cu = (m_idx % 2) == 1;
          e_rd = 1'b1;
          e_addr = ((cu ? m_lc : m_lp) * 128 + ln) % 512;
          evq.push_back('{cyc + LAT, cu, ln, m_idx == 2 * NL - 1});
          m_idx++;
        end
      end
      if (evq.size() > 0 && evq[0].t == cyc) begin
        e_valid = 1'b1; e_curr = evq[0].curr; e_line = evq[0].line; e_done = evq[0].last;
        void'(evq.pop_front());
      end
      e_busy = m_latch || (m_idx < 2 * NL) || e_valid || (evq.size() > 0);
    end
    #1;
    if (m_live) begin
      chk("rd_en", bus.o_rd_en, e_rd);
      if (e_rd || e_zero) chk("rd_addr", bus.o_rd_addr, e_addr);
      chk("data_valid", bus.o_data_valid, e_valid);
      if (e_valid) begin
        chk("data_is_curr", bus.o_data_is_curr, e_curr);
        chk("data_line", bus.o_data_line, e_line);
      end
      chk("frame_done", bus.o_frame_done, e_done);
      chk("frame_start", bus.o_frame_start, e_start);
      chk("busy", bus.o_busy, e_busy);
      chk("overrun", bus.o_overrun, e_ov);
    end
  end

  int t0, first_rd, last_rd, done_at, busy_last, done_line, done_curr;
  int cnt_rd, cnt_valid, cnt_vcurr, cnt_done, cnt_ov, cnt_busy;
  int stall_lo = -1, stall_hi = -1;
  int addrs[$];
  int f_start, f_ov, f_busy;
  int rot_c[3]  = '{1, 0, 2};
  int rot_p[3]  = '{2, 1, 0};
  int rot_a0[3] = '{256, 128, 0};
  int rot_a1[3] = '{128, 0, 256};
  int rot_al[3] = '{191, 63, 319};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // New-frame pulse in cycle t0; the decoder locations only become valid one cycle later.
  task automatic frame(input int c, input int p);
    bus.i_new_frame = 1'b1;
    bus.i_curr_frame_loc = 2'd3;
    bus.i_prev_frame_loc = 2'd3;
    t0 = cyc;
    tick();
    bus.i_new_frame = 1'b0;
    bus.i_curr_frame_loc = 2'(c);
    bus.i_prev_frame_loc = 2'(p);
    f_start = int'(bus.o_frame_start);
    f_ov = int'(bus.o_overrun);
    f_busy = int'(bus.o_busy);
  endtask

  task automatic observe(input int upto);
    cnt_rd = 0; cnt_valid = 0; cnt_vcurr = 0; cnt_done = 0; cnt_ov = 0; cnt_busy = 0;
    first_rd = -1; last_rd = -1; done_at = -1; busy_last = -1; done_line = -1; done_curr = -1;
    addrs.delete();
    while (cyc < upto) begin
      tick();
      bus.i_corr_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      if (bus.o_rd_en) begin
        cnt_rd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        addrs.push_back(int'(bus.o_rd_addr));
      end
      if (bus.o_data_valid) begin
        cnt_valid++;
        if (bus.o_data_is_curr) cnt_vcurr++;
      end
      if (bus.o_frame_done) begin
        cnt_done++; done_at = cyc; done_line = int'(bus.o_data_line); done_curr = int'(bus.o_data_is_curr);
      end
      if (bus.o_overrun) cnt_ov++;
      if (bus.o_busy) begin cnt_busy++; busy_last = cyc; end
    end
  endtask

  initial begin
    bus.i_new_frame = 1'b0;
    bus.i_curr_frame_loc = 2'd0;
    bus.i_prev_frame_loc = 2'd0;
    bus.i_corr_ready = 1'b1;
    rst = 1'b1;
    tick(); tick(); tick();
    chk("reset rd_en", bus.o_rd_en, 0);
    chk("reset rd_addr", bus.o_rd_addr, 0);
    chk("reset busy", bus.o_busy, 0);
    chk("reset valid", bus.o_data_valid, 0);
    rst = 1'b0;
    tick();

    // Warm-up pulse: no previous frame yet, so nothing happens.
    frame(0, 1);
    observe(cyc + 8);
    chk("warmup reads", cnt_rd, 0);
    chk("warmup busy", cnt_busy + f_busy, 0);

    // Pass A: prev=1, curr=0.
    frame(0, 1);
    observe(t0 + 140);
    chk("A frame_start", f_start, 1);
    chk("A first rd cycle", first_rd, t0 + 2);
    chk("A addr0", addrs[0], 128);
    chk("A addr1", addrs[1], 0);
    chk("A addr2", addrs[2], 129);
    chk("A addr3", addrs[3], 1);
    chk("A read count", cnt_rd, 128);

    // Pass B: prev=0, curr=2, full run with ready high.
    frame(2, 0);
    observe(t0 + 140);
    chk("B last rd cycle", last_rd, t0 + 129);
    chk("B last addr", addrs[addrs.size() - 1], 319);
    chk("B done cycle", done_at, t0 + 131);
    chk("B done is_curr", done_curr, 1);
    chk("B done line", done_line, 63);
    chk("B valids", cnt_valid, 128);
    chk("B curr valids", cnt_vcurr, 64);
    chk("B busy last cycle", busy_last, t0 + 131);

    // Pass C: 5-cycle backpressure in the middle.
    stall_lo = cyc + 40;
    stall_hi = cyc + 44;
    frame(1, 2);
    observe(t0 + 145);
    chk("C read count", cnt_rd, 128);
    chk("C first rd cycle", first_rd, t0 + 2);
    chk("C last rd cycle", last_rd, t0 + 134);
    chk("C done cycle", done_at, t0 + 136);
    chk("C valids", cnt_valid, 128);
    stall_lo = -1;
    stall_hi = -1;

    // Pass D: new frame arrives at line 30 of a running pass.
    frame(0, 2);
    observe(t0 + 62);
    frame(1, 2);
    chk("D overrun pulse", f_ov, 1);
    chk("D restart frame_start", f_start, 1);
    observe(t0 + 140);
    chk("D extra overruns", cnt_ov, 0);
    chk("D done count", cnt_done, 1);
    chk("D done cycle", done_at, t0 + 131);
    chk("D valids", cnt_valid, 128);
    chk("D restart addr0", addrs[0], 256);
    chk("D restart addr1", addrs[1], 128);

    // Pass E: reset while issuing, then a single pulse must only re-arm warm-up.
    frame(2, 1);
    observe(t0 + 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("E reset rd_en", bus.o_rd_en, 0);
    chk("E reset rd_addr", bus.o_rd_addr, 0);
    chk("E reset busy", bus.o_busy, 0);
    chk("E reset valid", bus.o_data_valid, 0);
    frame(0, 1);
    observe(t0 + 20);
    chk("E post-reset reads", cnt_rd, 0);
    chk("E post-reset busy", cnt_busy + f_busy, 0);

    // Location rotation through decoder states.
    for (int k = 0; k < 3; k++) begin
      frame(rot_c[k], rot_p[k]);
      observe(t0 + 140);
      chk("rot read count", cnt_rd, 128);
      chk("rot addr0", addrs[0], rot_a0[k]);
      chk("rot addr1", addrs[1], rot_a1[k]);
      chk("rot last addr", addrs[addrs.size() - 1], rot_al[k]);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
